// File: rtl/matcher_list_loader_pkg.sv
// Shared definitions for the matcher list loader.
// Holds the loader FSM state encoding so other matcher blocks can decode it.
package matcher_list_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matcher_list_loader.sv
// matcher_list_loader: streams a list of entries from a valid/ready source
// into a list memory. Every accepted beat is written one cycle later at
// FILTER_INDEX + entry index. Over- and under-length streams are flagged.
// Optional feature: define MATCHER_LOADER_CHECKSUM_EN to add a running XOR
// checksum output over the entries written by the current load.
module matcher_list_loader
  import matcher_list_loader_pkg::*;
#(
  parameter int LIST_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int FILTER_INDEX = 0
) (
  input  logic                  fclk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LIST_WIDTH:0]   length,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [LIST_WIDTH:0]   wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_long,
`ifdef MATCHER_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [LIST_WIDTH:0]   count
);

  // Largest loadable list (2**LIST_WIDTH entries) and the address base
  localparam logic [LIST_WIDTH:0] LIST_MAX   = {1'b1, {LIST_WIDTH{1'b0}}};
  localparam logic [LIST_WIDTH:0] FILTER_OFS = FILTER_INDEX[LIST_WIDTH:0];
  localparam logic [LIST_WIDTH:0] ONE        = {{LIST_WIDTH{1'b0}}, 1'b1};

  // Requested length saturates at the list capacity
  function automatic logic [LIST_WIDTH:0] clamp_len(input logic [LIST_WIDTH:0] l);
    return (l > LIST_MAX) ? LIST_MAX : l;
  endfunction

  state_t                state, state_n;
  logic [LIST_WIDTH:0]   len_q;
  logic [LIST_WIDTH:0]   count_q;
  logic [LIST_WIDTH:0]   count_inc;
  logic                  start_ok;
  logic                  beat_ok;
  logic                  beat_final;
  logic                  beat_short;
  logic                  wr_en_p1;
  logic [LIST_WIDTH:0]   wr_addr_p1;
  logic [DATA_WIDTH-1:0] wr_data_p1;

  assign count_inc = count_q + ONE;

  // Handshake and status decode straight from the state register
  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);
  assign count   = count_q;
  assign wr_en   = wr_en_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;

  // Next-state and per-cycle event decode
  always_comb begin
    state_n    = state;
    start_ok   = 1'b0;
    beat_ok    = 1'b0;
    beat_final = 1'b0;
    beat_short = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (s_valid) begin
          beat_ok = 1'b1;
          if (count_inc == len_q) begin
            beat_final = 1'b1;
            state_n    = DONE;
          end else if (s_last) begin
            beat_short = 1'b1;
            state_n    = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Load bookkeeping: length, entry count and error flags
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      len_q     <= '0;
      count_q   <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (start_ok) begin
      len_q     <= clamp_len(length);
      count_q   <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (beat_ok) begin
      count_q <= count_inc;
      if (beat_short)             err_short <= 1'b1;
      if (beat_final && !s_last)  err_long  <= 1'b1;
    end
  end

  // Stage p1: registered memory write, address/data hold between writes
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= beat_ok;
      if (beat_ok) begin
        wr_addr_p1 <= FILTER_OFS + count_q;
        wr_data_p1 <= s_data;
      end
    end
  end

`ifdef MATCHER_LOADER_CHECKSUM_EN
  // Running XOR taken at accept time so it already covers the last entry when done rises
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn)         checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (beat_ok)  checksum <= checksum ^ s_data;
  end
`endif

endmodule

// File: tb/tb_matcher_list_loader.sv
// Bench for matcher_list_loader: two instances (FILTER_INDEX 0 and 2) share
// the stimulus; expected writes are queued when beats are offered and
// compared when wr_en appears.
module tb_matcher_list_loader;

  localparam int LW = 4;
  localparam int DW = 64;

  logic          fclk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [LW:0]   length = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;

  logic          s_ready0, wr_en0, busy0, done0, err_short0, err_long0;
  logic [LW:0]   wr_addr0, count0;
  logic [DW-1:0] wr_data0;
  logic          s_ready2, wr_en2, busy2, done2, err_short2, err_long2;
  logic [LW:0]   wr_addr2, count2;
  logic [DW-1:0] wr_data2;
`ifdef MATCHER_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum0, checksum2;
`endif

  matcher_list_loader #(.LIST_WIDTH(LW), .DATA_WIDTH(DW), .FILTER_INDEX(0)) dut0 (
    .fclk(fclk), .rstn(rstn), .start(start), .length(length),
    .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .err_short(err_short0), .err_long(err_long0),
`ifdef MATCHER_LOADER_CHECKSUM_EN
    .checksum(checksum0),
`endif
    .count(count0)
  );

  matcher_list_loader #(.LIST_WIDTH(LW), .DATA_WIDTH(DW), .FILTER_INDEX(2)) dut2 (
    .fclk(fclk), .rstn(rstn), .start(start), .length(length),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2), .err_short(err_short2), .err_long(err_long2),
`ifdef MATCHER_LOADER_CHECKSUM_EN
    .checksum(checksum2),
`endif
    .count(count2)
  );

  always #5 fclk = ~fclk;

  typedef struct packed {
    logic [LW:0]   idx;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [LW:0]   mon_a2;
  int            errors = 0;
  int            checks = 0;
  logic [LW:0]   exp_idx = '0;
  logic [DW-1:0] exp_sum = '0;

  // Write monitor: every wr_en must match the oldest queued expectation
  always @(negedge fclk) begin
    if (wr_en0 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h, required no write", wr_addr0, wr_data0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_a2 = mon_e.idx + 5'd2;
        if (wr_addr0 !== mon_e.idx || wr_data0 !== mon_e.data) begin
          errors++;
          $display("FAIL write0 got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr0, wr_data0, mon_e.idx, mon_e.data);
        end
        checks++;
        if (wr_addr2 !== mon_a2 || wr_data2 !== mon_e.data) begin
          errors++;
          $display("FAIL write2 got addr=%0d data=%h, required addr=%0d data=%h",
                   wr_addr2, wr_data2, mon_a2, mon_e.data);
        end
      end
    end
    checks++;
    if (wr_en2 !== wr_en0 || done2 !== done0 || count2 !== count0) begin
      errors++;
      $display("FAIL dut_agree got wr_en2=%b done2=%b count2=%0d, required %b %b %0d",
               wr_en2, done2, count2, wr_en0, done0, count0);
    end
  end

  task automatic do_start(input logic [LW:0] len);
    @(posedge fclk); #1;
    start   = 1'b1;
    length  = len;
    exp_idx = '0;
    exp_sum = '0;
    @(posedge fclk); #1;
    start  = 1'b0;
    length = '0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last);
    wr_t w;
    @(posedge fclk); #1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge fclk);
    checks++;
    if (s_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready got %b, required 1", s_ready0);
    end
    w.idx  = exp_idx;
    w.data = d;
    exp_q.push_back(w);
    exp_idx = exp_idx + 5'd1;
    exp_sum = exp_sum ^ d;
  endtask

  task automatic end_beats();
    @(posedge fclk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge fclk);
    checks++;
    if ({s_ready0, wr_en0, busy0, done0, err_short0, err_long0} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b, required 000000",
               {s_ready0, wr_en0, busy0, done0, err_short0, err_long0});
    end
    checks++;
    if (count0 !== '0 || wr_addr0 !== '0 || wr_data0 !== '0) begin
      errors++;
      $display("FAIL reset_values got count=%0d addr=%0d data=%h, required 0 0 0",
               count0, wr_addr0, wr_data0);
    end
    @(posedge fclk); #1;
    rstn = 1'b1;
    @(negedge fclk);
    checks++;
    if (busy0 !== 1'b0 || s_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b s_ready=%b, required 0 0", busy0, s_ready0);
    end
  endtask

  task automatic test_basic();
    do_start(5'd3);
    @(negedge fclk);
    checks++;
    if (busy0 !== 1'b1 || count0 !== 5'd0) begin
      errors++;
      $display("FAIL basic_busy got busy=%b count=%0d, required 1 0", busy0, count0);
    end
    beat(64'hAAAA_0000_0000_000A, 1'b0);
    beat(64'hBBBB_0000_0000_000B, 1'b0);
    beat(64'hCCCC_0000_0000_000C, 1'b1);
    end_beats();
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || count0 !== 5'd3 || err_short0 !== 1'b0 || err_long0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b count=%0d es=%b el=%b, required 1 3 0 0",
               done0, count0, err_short0, err_long0);
    end
`ifdef MATCHER_LOADER_CHECKSUM_EN
    checks++;
    if (checksum0 !== exp_sum) begin
      errors++;
      $display("FAIL basic_checksum got %h, required %h", checksum0, exp_sum);
    end
`endif
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || count0 !== 5'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_after got done=%b busy=%b count=%0d pending=%0d, required 0 0 3 0",
               done0, busy0, count0, exp_q.size());
    end
  endtask

  task automatic test_short();
    do_start(5'd4);
    beat(64'h1111, 1'b0);
    beat(64'h2222, 1'b1);
    end_beats();
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || err_short0 !== 1'b1 || err_long0 !== 1'b0 || count0 !== 5'd2) begin
      errors++;
      $display("FAIL short_done got done=%b es=%b el=%b count=%0d, required 1 1 0 2",
               done0, err_short0, err_long0, count0);
    end
    repeat (2) @(negedge fclk);
    checks++;
    if (done0 !== 1'b0 || err_short0 !== 1'b1 || count0 !== 5'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL short_hold got done=%b es=%b count=%0d pending=%0d, required 0 1 2 0",
               done0, err_short0, count0, exp_q.size());
    end
  endtask

  task automatic test_long();
    do_start(5'd2);
    beat(64'h3333, 1'b0);
    beat(64'h4444, 1'b0);
    end_beats();
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || err_long0 !== 1'b1 || err_short0 !== 1'b0 ||
        count0 !== 5'd2 || s_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL long_done got done=%b el=%b es=%b count=%0d rdy=%b, required 1 1 0 2 0",
               done0, err_long0, err_short0, count0, s_ready0);
    end
    @(negedge fclk);
    checks++;
    if (s_ready0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_after got rdy=%b busy=%b done=%b pending=%0d, required 0 0 0 0",
               s_ready0, busy0, done0, exp_q.size());
    end
  endtask

  task automatic test_zero_length();
    do_start(5'd0);
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 5'd0 || wr_en0 !== 1'b0 ||
        err_long0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b count=%0d wr_en=%b el=%b, required 1 0 0 0 0",
               done0, busy0, count0, wr_en0, err_long0);
    end
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got done=%b, required 0", done0);
    end
  endtask

  task automatic test_gaps_reset();
    do_start(5'd3);
    beat(64'h5555, 1'b0);
    end_beats();
    repeat (3) @(negedge fclk);
    checks++;
    if (busy0 !== 1'b1 || count0 !== 5'd1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL stall got busy=%b count=%0d done=%b, required 1 1 0", busy0, count0, done0);
    end
    @(posedge fclk); #1;
    start  = 1'b1;
    length = 5'd0;
    @(posedge fclk); #1;
    start = 1'b0;
    @(negedge fclk);
    checks++;
    if (busy0 !== 1'b1 || count0 !== 5'd1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got busy=%b count=%0d done=%b, required 1 1 0",
               busy0, count0, done0);
    end
    @(posedge fclk); #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready0, wr_en0, busy0, done0, err_short0, err_long0} !== 6'b0 ||
        count0 !== '0 || wr_addr0 !== '0 || wr_data0 !== '0) begin
      errors++;
      $display("FAIL async_reset got flags=%b count=%0d addr=%0d data=%h, required all 0",
               {s_ready0, wr_en0, busy0, done0, err_short0, err_long0}, count0, wr_addr0, wr_data0);
    end
    @(posedge fclk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge fclk);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset cycle %0d got done=%b busy=%b, required 0 0",
                 i, done0, busy0);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_clamp_back_to_back();
    logic [DW-1:0] d;
    do_start(5'd31);
    for (int i = 0; i < 16; i++) begin
      d = {$urandom(), $urandom()};
      beat(d, (i == 15) ? 1'b1 : 1'b0);
    end
    end_beats();
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || count0 !== 5'd16 || err_short0 !== 1'b0 || err_long0 !== 1'b0) begin
      errors++;
      $display("FAIL clamp_done got done=%b count=%0d es=%b el=%b, required 1 16 0 0",
               done0, count0, err_short0, err_long0);
    end
`ifdef MATCHER_LOADER_CHECKSUM_EN
    checks++;
    if (checksum0 !== exp_sum) begin
      errors++;
      $display("FAIL clamp_checksum got %h, required %h", checksum0, exp_sum);
    end
`endif
    repeat (2) @(negedge fclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clamp_pending got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

`ifdef MATCHER_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start(5'd3);
    beat(64'h0F, 1'b0);
    beat(64'hF0, 1'b0);
    beat(64'hFF, 1'b1);
    end_beats();
    @(negedge fclk);
    checks++;
    if (done0 !== 1'b1 || checksum0 !== 64'h0) begin
      errors++;
      $display("FAIL checksum_zero got done=%b checksum=%h, required 1 0", done0, checksum0);
    end
    repeat (2) @(negedge fclk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_zero_length();
    test_gaps_reset();
    test_clamp_back_to_back();
`ifdef MATCHER_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1, "watchdog");
  end

endmodule
